// File: rtl/route_fifo.sv
// Elastic ready/valid buffer behind a tile routing mux, with a combinational bypass mode.
// Optional stall counter output is enabled by defining ROUTE_FIFO_STALL_CNT_EN.
module route_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             ASYNCRESET,
    input  logic [WIDTH-1:0] I,
    input  logic             I_valid,
    output logic             I_ready,
    output logic [WIDTH-1:0] O,
    output logic             O_valid,
    input  logic             O_ready,
    input  logic             bypass,
    input  logic             flush,
`ifdef ROUTE_FIFO_STALL_CNT_EN
    output logic [15:0]      stall_cnt,
`endif
    output logic [CNT_W-1:0] count
);
    localparam int unsigned PtrW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             buf_full, buf_valid, push, pop;

    // Full/empty come straight from the registered count, so a pop never frees a slot same-cycle.
    assign buf_full  = (count_q == CNT_W'(DEPTH));
    assign buf_valid = (count_q != '0);
    assign push      = ~bypass & I_valid & ~buf_full;
    assign pop       = ~bypass & buf_valid & O_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = (wr_ptr_q == PtrW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = (rd_ptr_q == PtrW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_d = count_q + 1'b1;
            end else if (pop && !push) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately unreset; validity is tracked by count_q alone.
    always_ff @(posedge CLK) begin
        if (push && !flush) begin
            mem_q[wr_ptr_q] <= I;
        end
    end

    always_comb begin
        if (bypass) begin
            O       = I;
            O_valid = I_valid;
            I_ready = O_ready;
        end else begin
            O       = buf_valid ? mem_q[rd_ptr_q] : '0;
            O_valid = buf_valid;
            I_ready = ~buf_full;
        end
    end

    assign count = count_q;

`ifdef ROUTE_FIFO_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (flush) begin
            stall_cnt_d = '0;
        end else if (~bypass && buf_valid && ~O_ready && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_route_fifo.sv
// Directed self-checking bench for route_fifo (DEPTH=2, WIDTH=32).
module tb_route_fifo;
    logic        CLK = 1'b0;
    logic        ASYNCRESET;
    logic [31:0] I;
    logic        I_valid;
    logic        I_ready;
    logic [31:0] O;
    logic        O_valid;
    logic        O_ready;
    logic        bypass;
    logic        flush;
    logic [1:0]  count;
`ifdef ROUTE_FIFO_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    route_fifo #(.WIDTH(32), .DEPTH(2)) dut (
        .CLK       (CLK),
        .ASYNCRESET(ASYNCRESET),
        .I         (I),
        .I_valid   (I_valid),
        .I_ready   (I_ready),
        .O         (O),
        .O_valid   (O_valid),
        .O_ready   (O_ready),
        .bypass    (bypass),
        .flush     (flush),
`ifdef ROUTE_FIFO_STALL_CNT_EN
        .stall_cnt (stall_cnt),
`endif
        .count     (count)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        ASYNCRESET = 1'b1;
        I = '0; I_valid = 1'b0; O_ready = 1'b0; bypass = 1'b0; flush = 1'b0;
        #12;
        ASYNCRESET = 1'b0;
        #1;
        check("rst_O", O, 32'h0);
        check("rst_O_valid", 32'(O_valid), 32'd0);
        check("rst_I_ready", 32'(I_ready), 32'd1);
        check("rst_count", 32'(count), 32'd0);
        step();
        check("idle_count", 32'(count), 32'd0);
        check("idle_O_valid", 32'(O_valid), 32'd0);

        // Fill with consumer stalled
        I = 32'hDEADBEEF; I_valid = 1'b1;
        step();
        check("push1_count", 32'(count), 32'd1);
        check("push1_O", O, 32'hDEADBEEF);
        check("push1_O_valid", 32'(O_valid), 32'd1);
        I = 32'h00000001;
        step();
        check("full_count", 32'(count), 32'd2);
        check("full_I_ready", 32'(I_ready), 32'd0);
        check("full_O", O, 32'hDEADBEEF);
        I = 32'h5;
        step();
        check("full_hold_count", 32'(count), 32'd2);
        check("full_hold_O", O, 32'hDEADBEEF);

        // Pop from full: no same-cycle push
        O_ready = 1'b1;
        check("full_pop_I_ready", 32'(I_ready), 32'd0);
        step();
        check("pop_from_full_count", 32'(count), 32'd1);
        check("pop_from_full_O", O, 32'h00000001);
        step();
        check("push_pop_count", 32'(count), 32'd1);
        check("push_pop_O", O, 32'h5);

        // Streaming with pointer wrap
        for (int k = 0; k < 10; k++) begin
            I = 32'(k);
            step();
            check("stream_O", O, 32'(k));
            check("stream_count", 32'(count), 32'd1);
        end
        I_valid = 1'b0;
        step();
        check("drain_count", 32'(count), 32'd0);
        check("drain_O_valid", 32'(O_valid), 32'd0);
        check("drain_O", O, 32'h0);

        // Asynchronous reset between edges with two words stored
        O_ready = 1'b0; I_valid = 1'b1; I = 32'hAA;
        step();
        I = 32'hBB;
        step();
        check("pre_rst_count", 32'(count), 32'd2);
        I_valid = 1'b0;
        #2;
        ASYNCRESET = 1'b1;
        #1;
        check("async_rst_count", 32'(count), 32'd0);
        check("async_rst_O_valid", 32'(O_valid), 32'd0);
        check("async_rst_O", O, 32'h0);
        #1;
        ASYNCRESET = 1'b0;

        // Flush from full, and flush dropping a concurrent push
        I_valid = 1'b1; I = 32'h11;
        step();
        I = 32'h22;
        step();
        check("pre_flush_count", 32'(count), 32'd2);
        flush = 1'b1; I = 32'h33;
        step();
        flush = 1'b0; I_valid = 1'b0;
        check("flush_full_count", 32'(count), 32'd0);
        check("flush_full_O_valid", 32'(O_valid), 32'd0);
        check("flush_full_O", O, 32'h0);
        I_valid = 1'b1; I = 32'h44;
        step();
        check("pre_flush2_count", 32'(count), 32'd1);
        flush = 1'b1; I = 32'h55; O_ready = 1'b1;
        step();
        flush = 1'b0; I_valid = 1'b0; O_ready = 1'b0;
        check("flush_push_count", 32'(count), 32'd0);
        check("flush_push_O_valid", 32'(O_valid), 32'd0);
        step();
        check("flush_push_dropped", 32'(count), 32'd0);

        // Bypass: pure combinational pass-through
        bypass = 1'b1; I = 32'hA5A5A5A5; I_valid = 1'b1; O_ready = 1'b0;
        #1;
        check("byp_O", O, 32'hA5A5A5A5);
        check("byp_O_valid", 32'(O_valid), 32'd1);
        check("byp_I_ready", 32'(I_ready), 32'd0);
        check("byp_count", 32'(count), 32'd0);
        O_ready = 1'b1;
        #1;
        check("byp_I_ready_follow", 32'(I_ready), 32'd1);
        step();
        check("byp_count_held", 32'(count), 32'd0);
        I_valid = 1'b0;
        #1;
        check("byp_O_valid_low", 32'(O_valid), 32'd0);
        bypass = 1'b0; O_ready = 1'b0;

`ifdef ROUTE_FIFO_STALL_CNT_EN
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("stall_flush", 32'(stall_cnt), 32'd0);
        I_valid = 1'b1; I = 32'h77;
        step();
        I_valid = 1'b0;
        check("stall_first", 32'(stall_cnt), 32'd0);
        step();
        step();
        step();
        check("stall_three", 32'(stall_cnt), 32'd3);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/route_fifo.md
Name: route_fifo

Overview:
- Elastic buffer placed directly downstream of the 9:1 default-zero routing mux in each tile track.
- Captures the 32-bit mux output under a ready/valid handshake and holds up to DEPTH words.
- Drives the next track segment.
- A config-driven bypass mode turns the stage into a pure wire, for tracks that need no buffering.

Parameters:
- WIDTH, 32: data width; matches the mux output width.
- DEPTH, 2: number of storage entries; power of two, ≥2.
- CNT_W, $clog2(DEPTH+1): derived width of the occupancy count; not overridden.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- ASYNCRESET  input  1  reset; asynchronous, active-high.
- I  input  WIDTH  write data; driven by the routing mux output.
- I_valid  input  1  producer has a word on I.
- I_ready  output  1  buffer accepts a word this cycle.
- O  output  WIDTH  head-of-buffer data.
- O_valid  output  1  O holds a valid word.
- O_ready  input  1  consumer accepts O this cycle.
- bypass  input  1  config bit (static during operation); 1 = pass-through.
- flush  input  1  synchronous clear of buffer contents.
- count  output  CNT_W  current occupancy, 0..DEPTH.

Behaviour:
- Reset (ASYNCRESET=1, takes effect immediately, independent of CLK):
  - wr_ptr, rd_ptr and count are 0.
  - O_valid=0 and O=0. Storage array is not reset.
  - I_ready=1 once reset is released (count=0).
  - Reset mid-transfer discards all stored words.
- Push: I_valid & I_ready at a rising edge.
  - Writes I to mem[wr_ptr].
  - wr_ptr increments and wraps DEPTH-1 → 0.
- Pop: O_valid & O_ready at a rising edge.
  - rd_ptr increments and wraps the same way.
- Occupancy update per edge:
  - push only: +1.
  - pop only: −1.
  - push and pop together: unchanged.
- I_ready = (count != DEPTH).
  - Registered-full semantics: when full, a same-cycle pop does NOT allow a same-cycle push. The slot frees on the next cycle.
- O_valid = (count != 0).
  - O = mem[rd_ptr] when O_valid=1, otherwise all-zero. Consumers never see stale data.
- Latency: a word pushed at edge N is visible on O/O_valid after edge N, i.e. 1 cycle. No combinational path from I to O in buffered mode.
- Full:
  - I_ready=0; I_valid is ignored.
  - Producer must hold I/I_valid stable until accepted.
- Empty: O_valid=0 and O=0, regardless of O_ready.
- flush=1 at an edge (buffered mode):
  - wr_ptr, rd_ptr and count go to 0.
  - Any push or pop in that same cycle is discarded. flush has priority.
- bypass=1:
  - O=I, O_valid=I_valid, I_ready=O_ready, all purely combinational.
  - Internal pointers and count are held, and count still reports the held value.
  - flush still clears the held state.
  - bypass changes only while count=0 (config-time contract). Behaviour is otherwise undefined.
- count is registered and equals the number of stored words after each edge.

Optional Feature:
- Macro ROUTE_FIFO_STALL_CNT_EN.
- When defined:
  - Adds output port stall_cnt, 16 bits.
  - Increments each edge where O_valid=1 & O_ready=0, in buffered mode only.
  - Saturates at 16'hFFFF.
  - Cleared to 0 by ASYNCRESET and by flush.
- When undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Reset, then idle → O=0, O_valid=0, I_ready=1, count=0. Assert ASYNCRESET between clock edges with count=2 → count=0, O_valid=0 immediately.
- O_ready=0; push 32'hDEADBEEF, then 32'h00000001 → count=2, I_ready=0, O=32'hDEADBEEF. Third word 32'h5 held on I is not accepted.
- From full, O_ready=1 for one cycle with I_valid=1 → pop DEADBEEF, no push, count=1. Next cycle 32'h5 is pushed with 00000001 popped, count stays 1.
- Continuous I_valid=O_ready=1 for 10 words 0..9 → O sequence 0..9, each one cycle after entry. Pointers wrap with no loss; count stays 1.
- count=2, assert flush together with I_valid=1 → count=0, O_valid=0, O=0 next cycle, pushed word dropped.
- Empty, bypass=1, I=32'hA5A5A5A5, I_valid=1, O_ready=0 → same cycle O=A5A5A5A5, O_valid=1, I_ready=0, count=0.
  - With ROUTE_FIFO_STALL_CNT_EN: 3 stalled cycles in buffered mode → stall_cnt=3.
